// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control unit: fetch/decode/execute/memory/write-back sequencer with halt state.
// Optional memory-wait timeout enabled by defining TIMEOUT_MEMORIA_EN (limit set by LIMITE_ESPERA).
module unidade_controle_multiciclo #(
    parameter int LIMITE_ESPERA = 16
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic [31:0] i_Instrucao,
    input  logic        i_Sinal_Desvio,
    input  logic        i_Memoria_Pronta,
    input  logic        i_Continuar,
    output logic [5:0]  o_Modo_Funcao_UC,
    output logic        o_Seleciona_Imediato,
    output logic        o_Le_Memoria,
    output logic        o_Escreve_Memoria,
    output logic        o_Escreve_Registrador,
    output logic        o_Escreve_IR,
    output logic        o_Escreve_PC,
    output logic [1:0]  o_Seleciona_PC,
    output logic [2:0]  o_Estado,
    output logic        o_Parado,
    output logic        o_Opcode_Invalido,
    output logic        o_Erro_Memoria
);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_MULT  = 6'b000010;
    localparam logic [5:0] OP_DIV   = 6'b000011;
    localparam logic [5:0] OP_AND   = 6'b000100;
    localparam logic [5:0] OP_OR    = 6'b000101;
    localparam logic [5:0] OP_NOT   = 6'b000110;
    localparam logic [5:0] OP_XOR   = 6'b000111;
    localparam logic [5:0] OP_SHR   = 6'b001000;
    localparam logic [5:0] OP_SHL   = 6'b001001;
    localparam logic [5:0] OP_BEQ   = 6'b001010;
    localparam logic [5:0] OP_BNE   = 6'b001011;
    localparam logic [5:0] OP_BLE   = 6'b001100;
    localparam logic [5:0] OP_BGR   = 6'b001101;
    localparam logic [5:0] OP_ADDI  = 6'b010000;
    localparam logic [5:0] OP_SUBI  = 6'b010001;
    localparam logic [5:0] OP_LOAD  = 6'b100000;
    localparam logic [5:0] OP_STORE = 6'b100001;
    localparam logic [5:0] OP_JMP   = 6'b100010;
    localparam logic [5:0] OP_NOP   = 6'b111110;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        MEMORIA    = 3'd3,
        ESCRITA    = 3'd4,
        PARADO     = 3'd5
    } estado_t;

    if (LIMITE_ESPERA < 1) begin : g_check_limite
        $error("LIMITE_ESPERA must be at least 1");
    end

    estado_t    r_state;
    estado_t    w_next;
    logic [5:0] r_opcode;

    logic       w_isAlu;
    logic       w_isBranch;
    logic       w_isLoad;
    logic       w_isStore;
    logic       w_isJmp;
    logic       w_isNop;
    logic       w_isHalt;
    logic       w_isValid;
    logic       w_waitHit;

    logic [5:0] w_modo;
    logic       w_imm;
    logic       w_le;
    logic       w_em;
    logic       w_er;
    logic       w_ir;
    logic       w_pc;
    logic [1:0] w_selPc;
    logic       w_inval;

    // Only the opcode field of the instruction word matters to the control unit.
    logic       w_unused_bits;
    assign w_unused_bits = &{1'b0, i_Instrucao[25:0]};

    assign w_isAlu    = r_opcode inside {OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_AND, OP_OR,
                                         OP_NOT, OP_XOR, OP_SHR, OP_SHL, OP_ADDI, OP_SUBI};
    assign w_isBranch = r_opcode inside {OP_BEQ, OP_BNE, OP_BLE, OP_BGR};
    assign w_isLoad   = (r_opcode == OP_LOAD);
    assign w_isStore  = (r_opcode == OP_STORE);
    assign w_isJmp    = (r_opcode == OP_JMP);
    assign w_isNop    = (r_opcode == OP_NOP);
    assign w_isHalt   = (r_opcode == OP_HALT);
    assign w_isValid  = w_isAlu | w_isBranch | w_isLoad | w_isStore | w_isJmp;

`ifdef TIMEOUT_MEMORIA_EN
    localparam int W_ESPERA = $clog2(LIMITE_ESPERA + 1);

    logic [W_ESPERA-1:0] r_wait;
    logic                r_erro;
    logic                w_esperando;

    assign w_esperando = ((r_state == BUSCA) || (r_state == MEMORIA)) && !i_Memoria_Pronta;
    assign w_waitHit   = w_esperando && (r_wait == W_ESPERA'(LIMITE_ESPERA - 1));

    // Wait counter restarts whenever the FSM changes state, so each wait is timed from entry.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_wait <= '0;
        end else if (w_next != r_state) begin
            r_wait <= '0;
        end else if (w_esperando) begin
            r_wait <= r_wait + W_ESPERA'(1);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_erro <= 1'b0;
        end else if (w_waitHit) begin
            r_erro <= 1'b1;
        end else if ((r_state == PARADO) && i_Continuar) begin
            r_erro <= 1'b0;
        end
    end

    assign o_Erro_Memoria = r_erro;
`else
    assign w_waitHit      = 1'b0;
    assign o_Erro_Memoria = 1'b0;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state  <= BUSCA;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == BUSCA) && i_Memoria_Pronta) begin
                r_opcode <= i_Instrucao[31:26];
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_modo  = 6'b000000;
        w_imm   = 1'b0;
        w_le    = 1'b0;
        w_em    = 1'b0;
        w_er    = 1'b0;
        w_ir    = 1'b0;
        w_pc    = 1'b0;
        w_selPc = 2'b00;
        w_inval = 1'b0;

        case (r_state)
            BUSCA: begin
                w_le = 1'b1;
                if (i_Memoria_Pronta) begin
                    w_ir   = 1'b1;
                    w_pc   = 1'b1;
                    w_next = DECODIFICA;
                end else if (w_waitHit) begin
                    w_next = PARADO;
                end
            end
            DECODIFICA: begin
                if (w_isHalt) begin
                    w_next = PARADO;
                end else if (w_isNop) begin
                    w_next = BUSCA;
                end else if (!w_isValid) begin
                    w_inval = 1'b1;
                    w_next  = BUSCA;
                end else begin
                    w_next = EXECUTA;
                end
            end
            EXECUTA: begin
                if (w_isAlu) begin
                    w_modo = r_opcode;
                    w_imm  = (r_opcode == OP_ADDI) || (r_opcode == OP_SUBI);
                    w_next = ESCRITA;
                end else if (w_isBranch) begin
                    w_modo  = r_opcode;
                    w_pc    = 1'b1;
                    w_selPc = {1'b0, i_Sinal_Desvio};
                    w_next  = BUSCA;
                end else if (w_isLoad || w_isStore) begin
                    w_modo = OP_ADD;
                    w_imm  = 1'b1;
                    w_next = MEMORIA;
                end else begin
                    if (w_isJmp) begin
                        w_pc    = 1'b1;
                        w_selPc = 2'b10;
                    end
                    w_next = BUSCA;
                end
            end
            MEMORIA: begin
                w_le = w_isLoad;
                w_em = w_isStore;
                if (i_Memoria_Pronta) begin
                    w_next = w_isLoad ? ESCRITA : BUSCA;
                end else if (w_waitHit) begin
                    w_next = PARADO;
                end
            end
            ESCRITA: begin
                w_er   = 1'b1;
                w_next = BUSCA;
            end
            PARADO: begin
                if (i_Continuar) begin
                    w_next = BUSCA;
                end
            end
            default: begin
                w_next = BUSCA;
            end
        endcase
    end

    // Reset masks every strobe immediately so nothing fires while it is held.
    assign o_Modo_Funcao_UC      = i_Reset ? 6'b000000 : w_modo;
    assign o_Seleciona_Imediato  = w_imm   & ~i_Reset;
    assign o_Le_Memoria          = w_le    & ~i_Reset;
    assign o_Escreve_Memoria     = w_em    & ~i_Reset;
    assign o_Escreve_Registrador = w_er    & ~i_Reset;
    assign o_Escreve_IR          = w_ir    & ~i_Reset;
    assign o_Escreve_PC          = w_pc    & ~i_Reset;
    assign o_Seleciona_PC        = i_Reset ? 2'b00 : w_selPc;
    assign o_Opcode_Invalido     = w_inval & ~i_Reset;
    assign o_Parado              = (r_state == PARADO) & ~i_Reset;
    assign o_Estado              = r_state;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for unidade_controle_multiciclo: table vectors, corner sequences and
// randomized instruction streams checked cycle by cycle against an instruction-level model.
module tb_unidade_controle_multiciclo;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instrucao;
    logic        desvio;
    logic        pronta;
    logic        continuar;
    logic [5:0]  modo;
    logic        selImm, leMem, escMem, escReg, escIR, escPC;
    logic [1:0]  selPC;
    logic [2:0]  estado;
    logic        parado, inval, erro;

    always #5 clock = ~clock;

    unidade_controle_multiciclo #(.LIMITE_ESPERA(16)) dut (
        .i_Clock              (clock),
        .i_Reset              (reset),
        .i_Instrucao          (instrucao),
        .i_Sinal_Desvio       (desvio),
        .i_Memoria_Pronta     (pronta),
        .i_Continuar          (continuar),
        .o_Modo_Funcao_UC     (modo),
        .o_Seleciona_Imediato (selImm),
        .o_Le_Memoria         (leMem),
        .o_Escreve_Memoria    (escMem),
        .o_Escreve_Registrador(escReg),
        .o_Escreve_IR         (escIR),
        .o_Escreve_PC         (escPC),
        .o_Seleciona_PC       (selPC),
        .o_Estado             (estado),
        .o_Parado             (parado),
        .o_Opcode_Invalido    (inval),
        .o_Erro_Memoria       (erro)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       parado, inval, erro, le, em, er, ir, pc;
        logic [1:0] sel;
        logic [5:0] modo;
        logic       imm;
    } outT;

    typedef struct {
        logic [5:0] op;
        logic       desv;
        int         waitMem;
        int         expCycles;
    } vecT;

    // Instruction classes used by the model
    localparam int C_ALU = 0, C_BR = 1, C_LD = 2, C_ST = 3, C_JMP = 4, C_NOP = 5, C_HALT = 6, C_INV = 7;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic expErro = 1'b0;

    function automatic int classOf(input logic [5:0] op);
        if (op <= 6'd9 || op == 6'b010000 || op == 6'b010001) return C_ALU;
        if (op >= 6'b001010 && op <= 6'b001101) return C_BR;
        if (op == 6'b100000) return C_LD;
        if (op == 6'b100001) return C_ST;
        if (op == 6'b100010) return C_JMP;
        if (op == 6'b111110) return C_NOP;
        if (op == 6'b111111) return C_HALT;
        return C_INV;
    endfunction

    function automatic outT idle(input logic [2:0] st);
        outT o;
        o = '0;
        o.st = st;
        o.erro = expErro;
        return o;
    endfunction

    function automatic outT actual();
        outT a;
        a.st = estado; a.parado = parado; a.inval = inval; a.erro = erro;
        a.le = leMem; a.em = escMem; a.er = escReg; a.ir = escIR; a.pc = escPC;
        a.sel = selPC; a.modo = modo; a.imm = selImm;
        return a;
    endfunction

    task automatic checkOutput(input string tag, input outT exp);
        outT act;
        act = actual();
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got st=%0d bits=%b, expected st=%0d bits=%b", tag, act.st, act, exp.st, exp);
        end
    endtask

    task automatic checkCount(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d cycles, expected %0d", tag, got, want);
        end
    endtask

    // One clock: drive at negedge, compare settled outputs before the next rising edge.
    task automatic applyStimulus(input logic p, input logic c, input logic d, input logic [31:0] ins,
                                 input string tag, input outT exp);
        @(negedge clock);
        pronta = p; continuar = c; desvio = d; instrucao = ins;
        #1;
        checkOutput(tag, exp);
        cyc++;
    endtask

    task automatic runInstr(input logic [5:0] op, input logic desv, input int wf, input int wm, output int n);
        int   start = cyc;
        int   cls = classOf(op);
        outT  e;
        logic [31:0] w;
        w = {op, 26'($urandom)};
        for (int i = 0; i < wf; i++) begin
            e = idle(0); e.le = 1'b1;
            applyStimulus(1'b0, 1'($urandom), 1'($urandom), $urandom, "fetch wait", e);
        end
        e = idle(0); e.le = 1'b1; e.ir = 1'b1; e.pc = 1'b1;
        applyStimulus(1'b1, 1'($urandom), 1'($urandom), w, "fetch", e);
        e = idle(1); e.inval = (cls == C_INV);
        applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), $urandom, "decode", e);
        if (cls == C_ALU || cls == C_BR || cls == C_LD || cls == C_ST || cls == C_JMP) begin
            e = idle(2);
            case (cls)
                C_ALU: begin e.modo = op; e.imm = (op == 6'b010000 || op == 6'b010001); end
                C_BR:  begin e.modo = op; e.pc = 1'b1; e.sel = {1'b0, desv}; end
                C_JMP: begin e.pc = 1'b1; e.sel = 2'b10; end
                default: e.imm = 1'b1;
            endcase
            applyStimulus(1'($urandom), 1'($urandom), desv, $urandom, "execute", e);
            if (cls == C_LD || cls == C_ST) begin
                e = idle(3); e.le = (cls == C_LD); e.em = (cls == C_ST);
                for (int i = 0; i < wm; i++)
                    applyStimulus(1'b0, 1'($urandom), 1'($urandom), $urandom, "memory wait", e);
                applyStimulus(1'b1, 1'($urandom), 1'($urandom), $urandom, "memory", e);
            end
            if (cls == C_ALU || cls == C_LD) begin
                e = idle(4); e.er = 1'b1;
                applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), $urandom, "writeback", e);
            end
        end
        n = cyc - start;
    endtask

    task automatic runHalt(input int n);
        outT e;
        e = idle(5); e.parado = 1'b1;
        for (int i = 0; i < n; i++)
            applyStimulus(1'($urandom), (i == n - 1), 1'($urandom), $urandom, "halted", e);
    endtask

    function automatic int expectedCycles(input int cls, input int wf, input int wm);
        case (cls)
            C_ALU:   return 4 + wf;
            C_BR:    return 3 + wf;
            C_JMP:   return 3 + wf;
            C_LD:    return 5 + wf + wm;
            C_ST:    return 4 + wf + wm;
            default: return 2 + wf;
        endcase
    endfunction

    vecT         vecs[$];
    logic [5:0]  validOps[21];
    int          n;
    outT         e;

    initial begin
        validOps = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'b010000, 6'b010001,
                     6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b100000, 6'b100001, 6'b100010,
                     6'b111110, 6'b111111};
        vecs.push_back('{6'b010000, 1'b0, 0, 4});
        vecs.push_back('{6'b000000, 1'b0, 0, 4});
        vecs.push_back('{6'b000111, 1'b1, 0, 4});
        vecs.push_back('{6'b001010, 1'b1, 0, 3});
        vecs.push_back('{6'b001010, 1'b0, 0, 3});
        vecs.push_back('{6'b001101, 1'b1, 0, 3});
        vecs.push_back('{6'b100000, 1'b0, 0, 5});
        vecs.push_back('{6'b100000, 1'b0, 3, 8});
        vecs.push_back('{6'b100001, 1'b0, 0, 4});
        vecs.push_back('{6'b100001, 1'b0, 2, 6});
        vecs.push_back('{6'b100010, 1'b0, 0, 3});
        vecs.push_back('{6'b111110, 1'b0, 0, 2});
        vecs.push_back('{6'b101010, 1'b0, 0, 2});
        vecs.push_back('{6'b111111, 1'b0, 0, 2});
        vecs.push_back('{6'b010001, 1'b0, 0, 4});

        reset = 1'b1; pronta = 1'b1; continuar = 1'b1; desvio = 1'b1; instrucao = 32'hFFFF_FFFF;
        repeat (2) @(negedge clock);
        #1;
        checkOutput("reset", idle(0));
        pronta = 1'b0;
        reset = 1'b0;

        foreach (vecs[k]) begin
            runInstr(vecs[k].op, vecs[k].desv, 0, vecs[k].waitMem, n);
            checkCount($sformatf("vector %0d cycles", k), n, vecs[k].expCycles);
            if (vecs[k].op == 6'b111111) runHalt(5);
        end

        // Reset in the middle of a memory wait, with ready also asserted, must win.
        e = idle(0); e.le = 1'b1; e.ir = 1'b1; e.pc = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, {6'b100000, 26'd7}, "fetch", e);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, "decode", idle(1));
        e = idle(2); e.imm = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, "execute", e);
        e = idle(3); e.le = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, "memory wait", e);
        @(negedge clock);
        reset = 1'b1; pronta = 1'b1;
        @(negedge clock);
        #1;
        checkOutput("reset mid-memory", idle(0));
        pronta = 1'b0;
        reset = 1'b0;

`ifdef TIMEOUT_MEMORIA_EN
        e = idle(0); e.le = 1'b1; e.ir = 1'b1; e.pc = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, {6'b100000, 26'd0}, "fetch", e);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, "decode", idle(1));
        e = idle(2); e.imm = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, "execute", e);
        e = idle(3); e.le = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, "timeout wait", e);
        expErro = 1'b1;
        runHalt(3);
        expErro = 1'b0;
        runInstr(6'b000001, 1'b0, 0, 0, n);
        checkCount("after timeout cycles", n, 4);
`else
        runInstr(6'b100000, 1'b0, 0, 20, n);
        checkCount("long memory wait cycles", n, 25);
`endif

        for (int k = 0; k < 60; k++) begin
            logic [5:0] op;
            int wf, wm;
            op = ($urandom_range(3) == 0) ? 6'($urandom_range(63)) : validOps[$urandom_range(20)];
            wf = $urandom_range(3);
            wm = $urandom_range(3);
            runInstr(op, 1'($urandom), wf, wm, n);
            checkCount($sformatf("random %0d op=%b cycles", k, op), n, expectedCycles(classOf(op), wf, wm));
            if (classOf(op) == C_HALT) runHalt($urandom_range(1, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
